wb_switch_n: RTL and testbench
==============================

# wb_switch_n

Parametrised single-master Wishbone address decoder and switch that routes the CPU bus to one of `NUM_SLAVES` slaves through `NUM_REGIONS` address/mask windows. It sits between the processor core and the ROM, Tube, RAM and future peripherals. It adds the following to the fixed four-slave switch:
- a registered decode;
- a per-transfer timeout watchdog;
- a selectable unmapped-address response (error or default-data ack);
- error capture status.

## Interface
- `NUM_SLAVES`, 4: number of slave ports, 1..16.
- `NUM_REGIONS`, 4: number of decode windows, 1..32.
- `ADDR_W`, 32: address width.
- `DATA_W`, 32: data width, multiple of 8.
- `REGION_ADDR`, {32'h0, 32'h01000000, 32'h03000000, 32'h0}: packed `NUM_REGIONS*ADDR_W` match values; region 0 is in the LSBs.
- `REGION_MASK`, {32'h03E00000, 32'h03000000, 32'h03000000, 32'h03FFFFFC}: packed masks.
- `REGION_SLAVE`, {4'd2, 4'd1, 4'd0, 4'd0}: packed 4-bit slave index per region.
- `TIMEOUT`, 255: number of cycles in ACTIVE before abort; 0 disables the watchdog.
- `ERR_ON_UNMAPPED`, 1: 1 = unmapped access gets `m_err_o`; 0 = it gets `m_ack_o` with `DEFAULT_DATA`.
- `DEFAULT_DATA`, 32'haaaaaaaa: read data returned on an unmapped ack.

Ports:
- `clk` in 1: system clock.
- `reset` in 1: asynchronous, active-high reset.
- `m_adr_i` in ADDR_W, `m_dat_i` in DATA_W, `m_sel_i` in DATA_W/8, `m_we_i` in 1, `m_cyc_i` in 1, `m_stb_i` in 1: master request.
- `m_dat_o` out DATA_W, `m_ack_o` out 1, `m_err_o` out 1: master response.
- `s_adr_o` out ADDR_W, `s_dat_o` out DATA_W, `s_sel_o` out DATA_W/8, `s_we_o` out 1: broadcast to all slaves, driven straight from the master inputs.
- `s_cyc_o` out NUM_SLAVES, `s_stb_o` out NUM_SLAVES: one-hot per-slave strobes.
- `s_dat_i` in NUM_SLAVES*DATA_W, `s_ack_i` in NUM_SLAVES, `s_err_i` in NUM_SLAVES: slave responses.
- `err_adr_o` out ADDR_W: address of the most recent failed transfer.
- `err_timeout_o` out 1: 1 = the last error was a timeout, 0 = it was unmapped or slave-signalled.
- `err_count_o` out 8: saturating count of errors.

## Operation
- Region hit: `(m_adr_i & REGION_MASK[r]) == (REGION_ADDR[r] & REGION_MASK[r])`. When regions overlap, the lowest-numbered hit wins.
- The FSM has three states: IDLE, ACTIVE and RESP.
- IDLE:
  - On `m_cyc_i & m_stb_i` with a region hit: register the slave index, clear the watchdog, go to ACTIVE.
  - On `m_cyc_i & m_stb_i` with no hit: go to RESP.
- ACTIVE:
  - `s_cyc_o[k] = m_cyc_i` and `s_stb_o[k] = m_stb_i` for the selected k only; all other slave strobes are 0.
  - `m_ack_o`, `m_err_o` and `m_dat_o` are combinational pass-throughs from slave k.
  - On `s_ack_i[k]` or `s_err_i[k]`: go to IDLE.
  - On `m_cyc_i` low: go to IDLE with no response.
  - When the watchdog reaches `TIMEOUT`: go to RESP with the timeout flag set. All slave strobes are 0 from that cycle on.
- RESP: asserts exactly one cycle of `m_err_o`, or, for an unmapped access with `ERR_ON_UNMAPPED=0`, `m_ack_o` with `m_dat_o = DEFAULT_DATA`. Then goes to IDLE.
- Error capture happens on every `m_err_o` pulse, whether from the switch or from a slave:
  - `err_adr_o` ← `m_adr_i`;
  - `err_timeout_o` ← timeout flag;
  - `err_count_o` increments and saturates at 255.
- Watchdog: an `$clog2(TIMEOUT+1)`-bit counter that increments every ACTIVE cycle without a response.
- In IDLE, `m_dat_o` is 0.

## Timing
- Reset values: every output is 0. Outputs fall to 0 asynchronously when `reset` asserts, including in the middle of a transfer; the slave sees its `cyc` drop.
- Request seen in cycle N → slave strobe in cycle N+1. The ack is combinational from the slave, so a zero-wait slave completes in N+1.
- Back-to-back requests have one IDLE cycle between them.
- Unmapped request in cycle N → response in cycle N+1.
- Timeout: the abort response arrives `TIMEOUT`+1 cycles after the request cycle.
- Slave ack arriving in the same cycle as the watchdog expiry: the ack wins and no error is recorded.
- `m_cyc_i` drop in the same cycle as a slave ack: the ack is passed through and the FSM returns to IDLE.

## Structure
- Package `wb_switch_pkg` holds:
  - the FSM state enum;
  - the default memory-map constants: ROM, TUBE, RAM base/mask and slave indices.
- One sub-module, `wb_addr_decode`: combinational region match plus priority encoder. Outputs are `hit` and `slave_idx`.

## Test plan
- Read from 0x00000000 → slave 0 strobed (region 0 beats region 3); the slave returns 0xE59FF018 in one cycle; the master sees ack at N+1.
- Write to 0x01000008 with sel=4'b0001 → only `s_cyc_o[1]`/`s_stb_o[1]` asserted; the broadcast address equals 0x01000008.
- Read from 0x02000000, `ERR_ON_UNMAPPED=1` → `m_err_o` high for one cycle at N+1; `err_adr_o`=0x02000000; `err_count_o`=1; `err_timeout_o`=0. Same read with `ERR_ON_UNMAPPED=0` → ack with data 0xAAAAAAAA.
- RAM read at 0x00100000 with the slave never acking, `TIMEOUT`=8 → `s_cyc_o[2]` drops and `m_err_o` pulses at cycle N+9; `err_timeout_o`=1.
- `reset` asserted in ACTIVE → all strobes and acks are 0 before the next clock edge. After release, an access to 0x03000000 routes to slave 0.
- 300 unmapped accesses → `err_count_o` saturates at 255.

Source files
------------

// File: rtl/wb_switch_pkg.sv
// Shared types and default memory map for the Wishbone address switch.
package wb_switch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_RESP   = 2'd2
    } wb_state_e;

    localparam logic [3:0] SLV_ROM  = 4'd0;
    localparam logic [3:0] SLV_TUBE = 4'd1;
    localparam logic [3:0] SLV_RAM  = 4'd2;

    // The boot window aliases the ROM reset vector at address 0 over the RAM.
    localparam logic [31:0] BOOT_BASE = 32'h0000_0000;
    localparam logic [31:0] BOOT_MASK = 32'h03FF_FFFC;
    localparam logic [31:0] ROM_BASE  = 32'h0300_0000;
    localparam logic [31:0] ROM_MASK  = 32'h0300_0000;
    localparam logic [31:0] TUBE_BASE = 32'h0100_0000;
    localparam logic [31:0] TUBE_MASK = 32'h0300_0000;
    localparam logic [31:0] RAM_BASE  = 32'h0000_0000;
    localparam logic [31:0] RAM_MASK  = 32'h03E0_0000;

endpackage

// File: rtl/wb_addr_decode.sv
// Combinational address/mask region match with lowest-region-wins priority.
module wb_addr_decode
    import wb_switch_pkg::*;
#(
    parameter int                           NUM_REGIONS  = 4,
    parameter int                           ADDR_W       = 32,
    parameter logic [NUM_REGIONS*ADDR_W-1:0] REGION_ADDR = '0,
    parameter logic [NUM_REGIONS*ADDR_W-1:0] REGION_MASK = '0,
    parameter logic [NUM_REGIONS*4-1:0]      REGION_SLAVE = '0
) (
    input  logic [ADDR_W-1:0] adr,
    output logic              hit,
    output logic [3:0]        slave_idx
);

    logic [ADDR_W-1:0] w_mask;
    logic [ADDR_W-1:0] w_base;

    always_comb begin
        hit       = 1'b0;
        slave_idx = '0;
        w_mask    = '0;
        w_base    = '0;
        // Walk from the top so the lowest-numbered hit is the last to write.
        for (int r = NUM_REGIONS - 1; r >= 0; r--) begin
            w_mask = REGION_MASK[r*ADDR_W +: ADDR_W];
            w_base = REGION_ADDR[r*ADDR_W +: ADDR_W];
            if ((adr & w_mask) == (w_base & w_mask)) begin
                hit       = 1'b1;
                slave_idx = REGION_SLAVE[r*4 +: 4];
            end
        end
    end

endmodule

// File: rtl/wb_switch_n.sv
// Single-master Wishbone switch: registered decode, per-transfer watchdog,
// configurable unmapped response and error capture.
//
// state     | meaning
// ST_IDLE   | waiting for cyc&stb; decode the address
// ST_ACTIVE | selected slave strobed, its response passed straight back
// ST_RESP   | one-cycle local response (unmapped or watchdog abort)
module wb_switch_n
    import wb_switch_pkg::*;
#(
    parameter int                             NUM_SLAVES      = 4,
    parameter int                             NUM_REGIONS     = 4,
    parameter int                             ADDR_W          = 32,
    parameter int                             DATA_W          = 32,
    parameter logic [NUM_REGIONS*ADDR_W-1:0]  REGION_ADDR     = {RAM_BASE, TUBE_BASE, ROM_BASE, BOOT_BASE},
    parameter logic [NUM_REGIONS*ADDR_W-1:0]  REGION_MASK     = {RAM_MASK, TUBE_MASK, ROM_MASK, BOOT_MASK},
    parameter logic [NUM_REGIONS*4-1:0]       REGION_SLAVE    = {SLV_RAM, SLV_TUBE, SLV_ROM, SLV_ROM},
    parameter int                             TIMEOUT         = 255,
    parameter bit                             ERR_ON_UNMAPPED = 1'b1,
    parameter logic [DATA_W-1:0]              DEFAULT_DATA    = 32'haaaaaaaa
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [ADDR_W-1:0]            m_adr_i,
    input  logic [DATA_W-1:0]            m_dat_i,
    input  logic [DATA_W/8-1:0]          m_sel_i,
    input  logic                         m_we_i,
    input  logic                         m_cyc_i,
    input  logic                         m_stb_i,
    output logic [DATA_W-1:0]            m_dat_o,
    output logic                         m_ack_o,
    output logic                         m_err_o,
    output logic [ADDR_W-1:0]            s_adr_o,
    output logic [DATA_W-1:0]            s_dat_o,
    output logic [DATA_W/8-1:0]          s_sel_o,
    output logic                         s_we_o,
    output logic [NUM_SLAVES-1:0]        s_cyc_o,
    output logic [NUM_SLAVES-1:0]        s_stb_o,
    input  logic [NUM_SLAVES*DATA_W-1:0] s_dat_i,
    input  logic [NUM_SLAVES-1:0]        s_ack_i,
    input  logic [NUM_SLAVES-1:0]        s_err_i,
    output logic [ADDR_W-1:0]            err_adr_o,
    output logic                         err_timeout_o,
    output logic [7:0]                   err_count_o
);

    localparam int                CNT_W     = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0]  WDOG_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    wb_state_e          r_state;
    wb_state_e          w_state_nxt;
    logic [3:0]         r_slave;
    logic [CNT_W-1:0]   r_wdog;
    logic               r_timeout;
    logic               r_unmapped;
    logic [ADDR_W-1:0]  r_err_adr;
    logic               r_err_timeout;
    logic [7:0]         r_err_cnt;

    logic               w_req;
    logic               w_hit;
    logic [3:0]         w_dec_idx;
    logic               w_sel_ack;
    logic               w_sel_err;
    logic [DATA_W-1:0]  w_sel_dat;
    logic               w_expire;

    wb_addr_decode #(
        .NUM_REGIONS  (NUM_REGIONS),
        .ADDR_W       (ADDR_W),
        .REGION_ADDR  (REGION_ADDR),
        .REGION_MASK  (REGION_MASK),
        .REGION_SLAVE (REGION_SLAVE)
    ) u_decode (
        .adr       (m_adr_i),
        .hit       (w_hit),
        .slave_idx (w_dec_idx)
    );

    assign w_req    = m_cyc_i & m_stb_i;
    assign w_expire = (TIMEOUT != 0) && (r_wdog == WDOG_LAST);

    // Broadcast lines are held low during reset so every output reads 0.
    assign s_adr_o = reset ? '0 : m_adr_i;
    assign s_dat_o = reset ? '0 : m_dat_i;
    assign s_sel_o = reset ? '0 : m_sel_i;
    assign s_we_o  = reset ? 1'b0 : m_we_i;

    always_comb begin
        w_sel_ack = 1'b0;
        w_sel_err = 1'b0;
        w_sel_dat = '0;
        for (int k = 0; k < NUM_SLAVES; k++) begin
            if (r_slave == 4'(k)) begin
                w_sel_ack = s_ack_i[k];
                w_sel_err = s_err_i[k];
                w_sel_dat = s_dat_i[k*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        m_dat_o     = '0;
        m_ack_o     = 1'b0;
        m_err_o     = 1'b0;
        s_cyc_o     = '0;
        s_stb_o     = '0;
        case (r_state)
            ST_IDLE: begin
                if (w_req) begin
                    w_state_nxt = w_hit ? ST_ACTIVE : ST_RESP;
                end
            end
            ST_ACTIVE: begin
                for (int k = 0; k < NUM_SLAVES; k++) begin
                    if (r_slave == 4'(k)) begin
                        s_cyc_o[k] = m_cyc_i;
                        s_stb_o[k] = m_stb_i;
                    end
                end
                m_ack_o = w_sel_ack;
                m_err_o = w_sel_err;
                m_dat_o = w_sel_dat;
                // A slave response beats both a master abort and the watchdog.
                if (w_sel_ack || w_sel_err) begin
                    w_state_nxt = ST_IDLE;
                end else if (!m_cyc_i) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_expire) begin
                    w_state_nxt = ST_RESP;
                end
            end
            ST_RESP: begin
                if (r_unmapped && !ERR_ON_UNMAPPED) begin
                    m_ack_o = 1'b1;
                    m_dat_o = DEFAULT_DATA;
                end else begin
                    m_err_o = 1'b1;
                end
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_slave    <= '0;
            r_wdog     <= '0;
            r_timeout  <= 1'b0;
            r_unmapped <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_req) begin
                        r_slave    <= w_dec_idx;
                        r_wdog     <= '0;
                        r_unmapped <= ~w_hit;
                        r_timeout  <= 1'b0;
                    end
                end
                ST_ACTIVE: begin
                    if (!(w_sel_ack || w_sel_err)) begin
                        r_wdog    <= r_wdog + CNT_W'(1);
                        r_timeout <= (w_state_nxt == ST_RESP);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_err_adr     <= '0;
            r_err_timeout <= 1'b0;
            r_err_cnt     <= '0;
        end else if (m_err_o) begin
            r_err_adr     <= m_adr_i;
            r_err_timeout <= (r_state == ST_RESP) && r_timeout;
            if (r_err_cnt != 8'hFF) begin
                r_err_cnt <= r_err_cnt + 8'd1;
            end
        end
    end

    assign err_adr_o     = r_err_adr;
    assign err_timeout_o = r_err_timeout;
    assign err_count_o   = r_err_cnt;

endmodule

// File: tb/tb_wb_switch_n.sv
// Bench for wb_switch_n: directed table, reset/saturation sequences and random
// transfers checked against an address-map reference model.
module tb_wb_switch_n;

    localparam int          NS       = 4;
    localparam int          AW       = 32;
    localparam int          DW       = 32;
    localparam int          TO       = 8;
    localparam logic [31:0] DEF_DATA = 32'hAAAAAAAA;

    localparam logic [31:0] RB [4] = '{32'h0000_0000, 32'h0300_0000, 32'h0100_0000, 32'h0000_0000};
    localparam logic [31:0] RM [4] = '{32'h03FF_FFFC, 32'h0300_0000, 32'h0300_0000, 32'h03E0_0000};
    localparam int          RS [4] = '{0, 0, 1, 2};

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic [AW-1:0]    m_adr;
    logic [DW-1:0]    m_dat;
    logic [3:0]       m_sel;
    logic             m_we, m_cyc, m_stb;
    logic [NS*DW-1:0] s_dat;
    logic [NS-1:0]    s_ack, s_err;

    logic [DW-1:0] a_mdat, b_mdat;
    logic          a_ack, a_err, b_ack, b_err;
    logic [AW-1:0] a_sadr, b_sadr;
    logic [DW-1:0] a_sdat, b_sdat;
    logic [3:0]    a_ssel, b_ssel;
    logic          a_swe, b_swe;
    logic [NS-1:0] a_scyc, a_sstb, b_scyc, b_sstb;
    logic [AW-1:0] a_eadr, b_eadr;
    logic          a_eto, b_eto;
    logic [7:0]    a_ecnt, b_ecnt;

    wb_switch_n #(.TIMEOUT(TO), .ERR_ON_UNMAPPED(1'b1)) dut_a (
        .clk(clk), .reset(reset),
        .m_adr_i(m_adr), .m_dat_i(m_dat), .m_sel_i(m_sel), .m_we_i(m_we),
        .m_cyc_i(m_cyc), .m_stb_i(m_stb),
        .m_dat_o(a_mdat), .m_ack_o(a_ack), .m_err_o(a_err),
        .s_adr_o(a_sadr), .s_dat_o(a_sdat), .s_sel_o(a_ssel), .s_we_o(a_swe),
        .s_cyc_o(a_scyc), .s_stb_o(a_sstb),
        .s_dat_i(s_dat), .s_ack_i(s_ack), .s_err_i(s_err),
        .err_adr_o(a_eadr), .err_timeout_o(a_eto), .err_count_o(a_ecnt)
    );

    wb_switch_n #(.TIMEOUT(TO), .ERR_ON_UNMAPPED(1'b0)) dut_b (
        .clk(clk), .reset(reset),
        .m_adr_i(m_adr), .m_dat_i(m_dat), .m_sel_i(m_sel), .m_we_i(m_we),
        .m_cyc_i(m_cyc), .m_stb_i(m_stb),
        .m_dat_o(b_mdat), .m_ack_o(b_ack), .m_err_o(b_err),
        .s_adr_o(b_sadr), .s_dat_o(b_sdat), .s_sel_o(b_ssel), .s_we_o(b_swe),
        .s_cyc_o(b_scyc), .s_stb_o(b_sstb),
        .s_dat_i(s_dat), .s_ack_i(s_ack), .s_err_i(s_err),
        .err_adr_o(b_eadr), .err_timeout_o(b_eto), .err_count_o(b_ecnt)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Expected error status, index 0 = error-on-unmapped instance, 1 = ack instance.
    logic [31:0] e_adr [2];
    logic        e_to  [2];
    int          e_cnt [2];

    typedef struct {
        logic [31:0] adr;
        logic        we;
        logic [31:0] wdat;
        logic [3:0]  sel;
        int          wait_c;
        logic        serr;
        logic [31:0] rdat;
        bit          mapped;
        int          slv;
    } vec_t;

    vec_t vecs [12];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic void ref_decode(input logic [31:0] adr, output bit mapped, output int slv);
        mapped = 1'b0;
        slv    = 0;
        for (int r = 0; r < 4; r++) begin
            if (!mapped && ((adr & RM[r]) == (RB[r] & RM[r]))) begin
                mapped = 1'b1;
                slv    = RS[r];
            end
        end
    endfunction

    task automatic log_err(input int d, input logic [31:0] adr, input logic to);
        e_adr[d] = adr;
        e_to[d]  = to;
        if (e_cnt[d] < 255) e_cnt[d] = e_cnt[d] + 1;
    endtask

    task automatic clear_status();
        for (int d = 0; d < 2; d++) begin
            e_adr[d] = '0;
            e_to[d]  = 1'b0;
            e_cnt[d] = 0;
        end
    endtask

    task automatic chk_status();
        chk("err_adr_a", a_eadr, e_adr[0]);
        chk("err_to_a",  a_eto,  e_to[0]);
        chk("err_cnt_a", a_ecnt, e_cnt[0]);
        chk("err_adr_b", b_eadr, e_adr[1]);
        chk("err_to_b",  b_eto,  e_to[1]);
        chk("err_cnt_b", b_ecnt, e_cnt[1]);
    endtask

    task automatic idle_cycle();
        @(posedge clk); #1;
        m_cyc = 1'b0; m_stb = 1'b0; s_ack = '0; s_err = '0;
        @(negedge clk);
        chk("gap_stb_a",  a_sstb, 0);
        chk("gap_resp_a", {a_ack, a_err}, 2'b00);
        chk("gap_resp_b", {b_ack, b_err}, 2'b00);
    endtask

    task automatic xfer(input logic [31:0] adr, input logic we, input logic [31:0] wdat,
                        input logic [3:0] sel, input int wait_c, input logic serr,
                        input logic [31:0] rdat, input bit mapped, input int slv);
        bit done;
        logic [NS-1:0] onehot;
        onehot = NS'(1) << slv;
        @(posedge clk); #1;
        m_adr = adr; m_we = we; m_dat = wdat; m_sel = sel; m_cyc = 1'b1; m_stb = 1'b1;
        s_ack = '0; s_err = '0;
        s_dat = {$urandom(), $urandom(), $urandom(), $urandom()};
        @(negedge clk);
        chk("idle_cyc_a",  a_scyc, 0);
        chk("idle_stb_b",  b_sstb, 0);
        chk("idle_resp_a", {a_ack, a_err}, 2'b00);
        chk("idle_dat_a",  a_mdat, 0);
        chk("bcast_adr",   a_sadr, adr);
        chk("bcast_dat",   a_sdat, wdat);
        chk("bcast_sel",   {a_ssel, a_swe}, {sel, we});
        chk_status();
        if (!mapped) begin
            @(posedge clk); #1;
            @(negedge clk);
            chk("unmap_resp_a", {a_ack, a_err}, 2'b01);
            chk("unmap_resp_b", {b_ack, b_err}, 2'b10);
            chk("unmap_dat_b",  b_mdat, DEF_DATA);
            chk("unmap_stb",    {a_sstb, b_sstb}, 0);
            log_err(0, adr, 1'b0);
        end else begin
            done = 1'b0;
            for (int j = 0; j <= TO && !done; j++) begin
                @(posedge clk); #1;
                if (j == wait_c && j < TO) begin
                    s_dat[slv*DW +: DW] = rdat;
                    s_ack[slv] = ~serr;
                    s_err[slv] = serr;
                end
                @(negedge clk);
                if (j < TO) begin
                    chk("act_cyc_a", a_scyc, onehot);
                    chk("act_stb_a", a_sstb, onehot);
                    chk("act_cyc_b", b_scyc, onehot);
                    if (j == wait_c) begin
                        chk("slv_resp_a", {a_ack, a_err}, {~serr, serr});
                        chk("slv_resp_b", {b_ack, b_err}, {~serr, serr});
                        if (!serr) chk("slv_dat_a", a_mdat, rdat);
                        if (serr) begin
                            log_err(0, adr, 1'b0);
                            log_err(1, adr, 1'b0);
                        end
                        done = 1'b1;
                    end else begin
                        chk("wait_resp_a", {a_ack, a_err}, 2'b00);
                    end
                end else begin
                    chk("to_cyc",    {a_scyc, b_scyc}, 0);
                    chk("to_resp_a", {a_ack, a_err}, 2'b01);
                    chk("to_resp_b", {b_ack, b_err}, 2'b01);
                    log_err(0, adr, 1'b1);
                    log_err(1, adr, 1'b1);
                    done = 1'b1;
                end
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        bit          mp;
        int          sv;
        logic [31:0] adr;

        reset = 1'b1;
        m_adr = '0; m_dat = '0; m_sel = '0; m_we = 1'b0; m_cyc = 1'b0; m_stb = 1'b0;
        s_dat = '0; s_ack = '0; s_err = '0;
        clear_status();
        #1;
        chk("rst_resp",  {a_ack, a_err, b_ack, b_err}, 0);
        chk("rst_strb",  {a_scyc, a_sstb, b_scyc, b_sstb}, 0);
        chk("rst_stat",  {a_eadr, a_eto, a_ecnt}, 0);
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b0;

        vecs[0]  = '{32'h0000_0000, 1'b0, 32'h0,          4'hF, 0,  1'b0, 32'hE59F_F018, 1'b1, 0};
        vecs[1]  = '{32'h0100_0008, 1'b1, 32'h1234_5678, 4'h1, 0,  1'b0, 32'h0,         1'b1, 1};
        vecs[2]  = '{32'h0200_0000, 1'b0, 32'h0,          4'hF, 0,  1'b0, 32'h0,         1'b0, 0};
        vecs[3]  = '{32'h0010_0000, 1'b0, 32'h0,          4'hF, 99, 1'b0, 32'h0,         1'b1, 2};
        vecs[4]  = '{32'h0300_0000, 1'b0, 32'h0,          4'hF, 3,  1'b0, 32'hCAFE_F00D, 1'b1, 0};
        vecs[5]  = '{32'h0000_0004, 1'b1, 32'hDEAD_BEEF, 4'hC, 7,  1'b0, 32'h5555_0000, 1'b1, 2};
        vecs[6]  = '{32'h0100_FFFC, 1'b0, 32'h0,          4'hF, 8,  1'b0, 32'h7777_7777, 1'b1, 1};
        vecs[7]  = '{32'h001F_FFFC, 1'b0, 32'h0,          4'hF, 2,  1'b1, 32'h0,         1'b1, 2};
        vecs[8]  = '{32'h0020_0000, 1'b0, 32'h0,          4'hF, 0,  1'b0, 32'h0,         1'b0, 0};
        vecs[9]  = '{32'h0400_0000, 1'b0, 32'h0,          4'hF, 1,  1'b0, 32'h1122_3344, 1'b1, 0};
        vecs[10] = '{32'h03FF_FFFC, 1'b1, 32'hA5A5_5A5A, 4'h3, 0,  1'b0, 32'h0,         1'b1, 0};
        vecs[11] = '{32'h0000_0003, 1'b0, 32'h0,          4'hF, 0,  1'b0, 32'h0F0F_0F0F, 1'b1, 0};

        for (int i = 0; i < 12; i++) begin
            xfer(vecs[i].adr, vecs[i].we, vecs[i].wdat, vecs[i].sel, vecs[i].wait_c,
                 vecs[i].serr, vecs[i].rdat, vecs[i].mapped, vecs[i].slv);
            if (i % 2 == 1) idle_cycle();
        end
        idle_cycle();
        chk_status();

        // Reset asserted while a RAM access is active: everything drops before the next edge.
        @(posedge clk); #1;
        m_adr = 32'h0010_0000; m_cyc = 1'b1; m_stb = 1'b1; m_sel = 4'hF; m_we = 1'b0;
        @(posedge clk); #1;
        chk("pre_rst_cyc", a_scyc, 4'b0100);
        #2;
        s_dat[2*DW +: DW] = 32'h1357_9BDF;
        s_ack[2] = 1'b1;
        #1;
        chk("pre_rst_ack", {a_ack, a_mdat}, {1'b1, 32'h1357_9BDF});
        reset = 1'b1;
        #1;
        chk("mid_rst_strb", {a_scyc, a_sstb, b_scyc, b_sstb}, 0);
        chk("mid_rst_resp", {a_ack, a_err, b_ack, b_err}, 0);
        chk("mid_rst_dat",  {a_mdat, a_sadr}, 0);
        chk("mid_rst_cnt",  {a_ecnt, b_ecnt}, 0);
        @(posedge clk); #1;
        s_ack = '0; m_cyc = 1'b0; m_stb = 1'b0;
        reset = 1'b0;
        clear_status();
        xfer(32'h0300_0000, 1'b0, 32'h0, 4'hF, 0, 1'b0, 32'h2468_ACE0, 1'b1, 0);
        idle_cycle();

        for (int i = 0; i < 200; i++) begin
            logic [31:0] wd;
            case ($urandom_range(0, 3))
                0: adr = $urandom();
                1: adr = 32'h0300_0000 | ($urandom() & 32'h00FF_FFFC);
                2: adr = 32'h0100_0000 | ($urandom() & 32'h00FF_FFFC);
                default: adr = $urandom() & 32'h003F_FFFC;
            endcase
            wd = $urandom();
            ref_decode(adr, mp, sv);
            xfer(adr, 1'($urandom_range(0, 1)), wd, 4'($urandom_range(0, 15)),
                 $urandom_range(0, 10), ($urandom_range(0, 7) == 0), $urandom(), mp, sv);
            if ($urandom_range(0, 1) == 1) idle_cycle();
        end
        idle_cycle();
        chk_status();

        for (int i = 0; i < 300; i++) begin
            adr = 32'h0200_0000 + 32'(i * 4);
            ref_decode(adr, mp, sv);
            xfer(adr, 1'b0, 32'h0, 4'hF, 0, 1'b0, 32'h0, mp, sv);
            idle_cycle();
        end
        chk_status();
        chk("sat_cnt_a", a_ecnt, 8'd255);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
